// File: rtl/axis2avst_if.sv
// AXI-Stream and Avalon-ST signal bundles used by the axis2avst bridge.
interface axis_if #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (
      output tdata, tkeep, tvalid, tlast, tuser,
      input  tready
   );
   modport slave (
      input  tdata, tkeep, tvalid, tlast, tuser,
      output tready
   );
endinterface

interface avst_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int EMPTY_WIDTH = 3
);
   logic [DATA_WIDTH-1:0]  data;
   logic                   valid;
   logic                   ready;
   logic                   startofpacket;
   logic                   endofpacket;
   logic [EMPTY_WIDTH-1:0] empty;
   logic                   error;

   modport master (
      output data, valid, startofpacket, endofpacket, empty, error,
      input  ready
   );
   modport slave (
      input  data, valid, startofpacket, endofpacket, empty, error,
      output ready
   );
endinterface

// File: rtl/axis2avst.sv
// AXI-Stream to Avalon-ST bridge: packet framing, byte ordering and
// a beat FIFO that absorbs in-flight beats for readyLatency 0..N.
module axis2avst #(
   parameter int DATA_WIDTH    = 64,
   parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
   parameter bit KEEP_ENABLE   = (DATA_WIDTH > 8),
   parameter int EMPTY_WIDTH   = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1,
   parameter bit BYTE_REVERSE  = 1'b0,
   parameter int READY_LATENCY = 0,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   axis_if.slave  axis,
   avst_if.master avst
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(KEEP_WIDTH + 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  data;
      logic                   sop;
      logic                   eop;
      logic [EMPTY_WIDTH-1:0] empty;
      logic                   error;
   } beat_t;

   beat_t                 mem [FIFO_DEPTH];
   beat_t                 wr_beat;
   beat_t                 head;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [KEEP_WIDTH-1:0] keep;
   logic [OW-1:0]         ones;
   logic                  in_packet;
   logic                  has_data;
   logic                  push;
   logic                  pop;

   assign axis.tready = rst_n && (count < CW'(FIFO_DEPTH));
   assign push        = axis.tvalid && axis.tready;
   assign keep        = KEEP_ENABLE ? axis.tkeep : '1;
   assign has_data    = (count != '0);
   assign head        = mem[rd_ptr];

   always_comb begin
      ones = '0;
      for (int i = 0; i < KEEP_WIDTH; i++)
         ones = ones + OW'(keep[i]);
   end

   always_comb begin
      wr_beat = '0;
      for (int i = 0; i < KEEP_WIDTH; i++)
         wr_beat.data[8*i +: 8] = BYTE_REVERSE ?
            axis.tdata[8*(KEEP_WIDTH-1-i) +: 8] : axis.tdata[8*i +: 8];
      wr_beat.sop = !in_packet;
      wr_beat.eop = axis.tlast;
      // An all-zero tkeep on the last beat is a malformed frame end.
      if (axis.tlast) begin
         wr_beat.error = axis.tuser || (keep == '0);
         if (KEEP_ENABLE)
            wr_beat.empty = (keep == '0) ? EMPTY_WIDTH'(KEEP_WIDTH - 1) :
                            EMPTY_WIDTH'(KEEP_WIDTH - int'(ones));
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_beat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         in_packet <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr    <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            in_packet <= !axis.tlast;
         end
         if (pop)
            rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   if (READY_LATENCY == 0) begin : g_rl0
      assign pop                = has_data && avst.ready;
      assign avst.valid         = has_data;
      assign avst.data          = has_data ? head.data : '0;
      assign avst.startofpacket = has_data && head.sop;
      assign avst.endofpacket   = has_data && head.eop;
      assign avst.empty         = has_data ? head.empty : '0;
      assign avst.error         = has_data && head.error;
   end else begin : g_rln
      beat_t out_q;
      logic  valid_q;
      logic  permit;

      // permit = sink ready as sampled READY_LATENCY cycles before the
      // cycle this edge launches.
      if (READY_LATENCY == 1) begin : g_l1
         assign permit = avst.ready;
      end else begin : g_ln
         localparam int DL = READY_LATENCY - 1;
         logic [DL-1:0] rdy_dly;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               rdy_dly <= '0;
            else
               rdy_dly <= DL'({rdy_dly, avst.ready});
         end
         assign permit = rdy_dly[DL-1];
      end

      assign pop = permit && has_data;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            out_q   <= '0;
         end else begin
            valid_q <= pop;
            if (pop)
               out_q <= head;
         end
      end

      assign avst.valid         = valid_q;
      assign avst.data          = out_q.data;
      assign avst.startofpacket = out_q.sop;
      assign avst.endofpacket   = out_q.eop;
      assign avst.empty         = out_q.empty;
      assign avst.error         = out_q.error;
   end

endmodule

// File: tb/tb_axis2avst.sv
// Self-checking bench for axis2avst: readyLatency 0 and 2 instances,
// directed framing cases and randomized traffic against a queue model.
module tb_axis2avst;
   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  empty;
      logic        error;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   axis_if #(.DATA_WIDTH(64)) a0 ();
   avst_if #(.DATA_WIDTH(64), .EMPTY_WIDTH(3)) v0 ();
   axis_if #(.DATA_WIDTH(64)) a2 ();
   avst_if #(.DATA_WIDTH(64), .EMPTY_WIDTH(3)) v2 ();

   axis2avst #(
      .READY_LATENCY(0),
      .FIFO_DEPTH(4)
   ) dut0 (
      .clk(clk),
      .rst_n(rst_n),
      .axis(a0),
      .avst(v0)
   );

   axis2avst #(
      .BYTE_REVERSE(1'b1),
      .READY_LATENCY(2),
      .FIFO_DEPTH(4)
   ) dut2 (
      .clk(clk),
      .rst_n(rst_n),
      .axis(a2),
      .avst(v2)
   );

   exp_t obs0;
   exp_t obs2;
   assign obs0 = {v0.data, v0.startofpacket, v0.endofpacket, v0.empty, v0.error};
   assign obs2 = {v2.data, v2.startofpacket, v2.endofpacket, v2.empty, v2.error};

   always #5 clk = ~clk;

   // Expected Avalon beat from the AXI beat and the framing rules.
   function automatic exp_t model(input logic [63:0] d, input logic [7:0] k,
                                  input logic last, input logic user,
                                  input logic sop, input logic rev);
      exp_t e;
      e.data = d;
      if (rev)
         for (int i = 0; i < 8; i++)
            e.data[8*i +: 8] = d[56-8*i +: 8];
      e.sop   = sop;
      e.eop   = last;
      e.empty = 3'd0;
      e.error = 1'b0;
      if (last) begin
         e.empty = (k == 8'h00) ? 3'd7 : 3'(8 - $countones(k));
         e.error = user || (k == 8'h00);
      end
      return e;
   endfunction

   function automatic logic [7:0] rand_keep();
      int n;
      n = $urandom_range(0, 8);
      return 8'((16'd1 << n) - 16'd1);
   endfunction

   task automatic idle();
      a0.tvalid = 1'b0; a0.tdata = '0; a0.tkeep = '0;
      a0.tlast  = 1'b0; a0.tuser = 1'b0;
      a2.tvalid = 1'b0; a2.tdata = '0; a2.tkeep = '0;
      a2.tlast  = 1'b0; a2.tuser = 1'b0;
      v0.ready  = 1'b0;
      v2.ready  = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (v0.valid !== 1'b0 || a0.tready !== 1'b0) begin
         bad++;
         $display("FAIL reset_l0: valid=%b tready=%b want 0 0", v0.valid, a0.tready);
      end
      total++;
      if (obs0 !== '0) begin
         bad++;
         $display("FAIL reset_fields_l0: got %h want 0", obs0);
      end
      total++;
      if (v2.valid !== 1'b0 || a2.tready !== 1'b0) begin
         bad++;
         $display("FAIL reset_l2: valid=%b tready=%b want 0 0", v2.valid, a2.tready);
      end
      total++;
      if (obs2 !== '0) begin
         bad++;
         $display("FAIL reset_fields_l2: got %h want 0", obs2);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (a0.tready !== 1'b1 || v0.valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: tready=%b valid=%b want 1 0", a0.tready, v0.valid);
      end
   endtask

   task automatic test_basic_frame();
      logic [63:0] d [3];
      exp_t e;
      d[0] = 64'h0011223344556677;
      d[1] = 64'h8899aabbccddeeff;
      d[2] = 64'hdeadbeefcafef00d;
      v0.ready = 1'b1;
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = model(d[i-1], (i == 3) ? 8'h0f : 8'hff, i == 3, 1'b0, i == 1, 1'b0);
            total++;
            if (v0.valid !== 1'b1 || obs0 !== e) begin
               bad++;
               $display("FAIL basic_beat%0d: valid=%b got %h want %h", i - 1, v0.valid, obs0, e);
            end
            if (i == 3) begin
               total++;
               if (v0.empty !== 3'd4 || v0.error !== 1'b0 || v0.endofpacket !== 1'b1) begin
                  bad++;
                  $display("FAIL basic_last: empty=%0d err=%b eop=%b want 4 0 1",
                           v0.empty, v0.error, v0.endofpacket);
               end
            end
         end
         if (i < 3) begin
            a0.tvalid = 1'b1;
            a0.tdata  = d[i];
            a0.tkeep  = (i == 2) ? 8'h0f : 8'hff;
            a0.tlast  = (i == 2);
            a0.tuser  = 1'b0;
         end else begin
            a0.tvalid = 1'b0;
         end
      end
      @(negedge clk);
      total++;
      if (v0.valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_idle: valid=%b want 0", v0.valid);
      end
   endtask

   task automatic test_fields();
      logic [63:0] d [4];
      logic [7:0]  k [4];
      logic        l [4];
      logic        u [4];
      logic [5:0]  x [4];
      k[0] = 8'hff; l[0] = 1'b1; u[0] = 1'b1; x[0] = 6'b1_1_000_1;
      k[1] = 8'hff; l[1] = 1'b0; u[1] = 1'b1; x[1] = 6'b1_0_000_0;
      k[2] = 8'h03; l[2] = 1'b1; u[2] = 1'b0; x[2] = 6'b0_1_110_0;
      k[3] = 8'h00; l[3] = 1'b1; u[3] = 1'b0; x[3] = 6'b1_1_111_1;
      for (int i = 0; i < 4; i++)
         d[i] = {$urandom, $urandom};
      v0.ready = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            total++;
            if (v0.valid !== 1'b1 || v0.data !== d[i-1] ||
                {obs0.sop, obs0.eop, obs0.empty, obs0.error} !== x[i-1]) begin
               bad++;
               $display("FAIL fields_beat%0d: valid=%b data=%h flags=%b want data=%h flags=%b",
                        i - 1, v0.valid, v0.data,
                        {obs0.sop, obs0.eop, obs0.empty, obs0.error}, d[i-1], x[i-1]);
            end
         end
         if (i < 4) begin
            a0.tvalid = 1'b1;
            a0.tdata  = d[i];
            a0.tkeep  = k[i];
            a0.tlast  = l[i];
            a0.tuser  = u[i];
         end else begin
            a0.tvalid = 1'b0;
         end
      end
   endtask

   task automatic test_random(input int frames);
      exp_t        q [$];
      exp_t        pend;
      bit          have_pend = 1'b0;
      bit          acc = 1'b1;
      bit          inpkt = 1'b0;
      int          sent = 0;
      int          cyc = 0;
      int          left;
      logic [63:0] d;
      logic [7:0]  k;
      logic        last;
      logic        user;
      left = $urandom_range(1, 20);
      d    = {$urandom, $urandom};
      last = (left == 1);
      k    = last ? rand_keep() : 8'hff;
      user = 1'($urandom_range(0, 1));
      a0.tvalid = 1'b0;
      while ((sent < frames || q.size() > 0 || have_pend) && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (sent >= frames)
            a0.tvalid = 1'b0;
         else if (acc || !a0.tvalid)
            a0.tvalid = ($urandom_range(0, 3) != 0);
         acc = 1'b0;
         a0.tdata = d;
         a0.tkeep = k;
         a0.tlast = last;
         a0.tuser = user;
         v0.ready = ($urandom_range(0, 3) != 0);
         #1;
         if (have_pend) begin
            q.push_back(pend);
            have_pend = 1'b0;
         end
         total++;
         if (a0.tready !== (q.size() < 4)) begin
            bad++;
            $display("FAIL rand_tready: got %b want %b at occupancy %0d",
                     a0.tready, q.size() < 4, q.size());
         end
         total++;
         if (v0.valid !== (q.size() > 0)) begin
            bad++;
            $display("FAIL rand_valid: got %b want %b", v0.valid, q.size() > 0);
         end
         if (v0.valid === 1'b1 && v0.ready && q.size() > 0) begin
            total++;
            if (obs0 !== q[0]) begin
               bad++;
               $display("FAIL rand_beat: got %h want %h", obs0, q[0]);
            end
            void'(q.pop_front());
         end
         if (a0.tvalid && a0.tready === 1'b1) begin
            pend      = model(d, k, last, user, !inpkt, 1'b0);
            have_pend = 1'b1;
            acc       = 1'b1;
            inpkt     = !last;
            if (last) begin
               sent++;
               left = $urandom_range(1, 20);
            end else begin
               left--;
            end
            d    = {$urandom, $urandom};
            last = (left == 1);
            k    = last ? rand_keep() : 8'hff;
            user = 1'($urandom_range(0, 1));
         end
      end
      total++;
      if (cyc >= 40000) begin
         bad++;
         $display("FAIL rand_timeout: frames=%0d of %0d queued=%0d", sent, frames, q.size());
      end
      @(negedge clk);
      a0.tvalid = 1'b0;
      v0.ready  = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      logic [63:0] y;
      exp_t e;
      v0.ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         a0.tvalid = 1'b1;
         a0.tdata  = {$urandom, $urandom};
         a0.tkeep  = 8'hff;
         a0.tlast  = 1'b0;
         a0.tuser  = 1'b0;
      end
      @(negedge clk);
      a0.tvalid = 1'b0;
      total++;
      if (v0.valid !== 1'b1) begin
         bad++;
         $display("FAIL mid_buffered: valid=%b want 1", v0.valid);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (v0.valid !== 1'b0 || a0.tready !== 1'b0) begin
         bad++;
         $display("FAIL mid_async: valid=%b tready=%b want 0 0", v0.valid, a0.tready);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      y         = {$urandom, $urandom};
      v0.ready  = 1'b1;
      a0.tvalid = 1'b1;
      a0.tdata  = y;
      a0.tkeep  = 8'hff;
      a0.tlast  = 1'b0;
      a0.tuser  = 1'b0;
      @(negedge clk);
      a0.tvalid = 1'b0;
      e = model(y, 8'hff, 1'b0, 1'b0, 1'b1, 1'b0);
      total++;
      if (v0.valid !== 1'b1 || obs0 !== e) begin
         bad++;
         $display("FAIL mid_sop: valid=%b got %h want %h", v0.valid, obs0, e);
      end
      @(negedge clk);
      total++;
      if (v0.valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_stale: valid=%b data=%h want valid 0", v0.valid, v0.data);
      end
      v0.ready = 1'b0;
   endtask

   task automatic test_byte_reverse();
      int n = 0;
      v2.ready = 1'b1;
      repeat (3) @(negedge clk);
      a2.tvalid = 1'b1;
      a2.tdata  = 64'h0706050403020100;
      a2.tkeep  = 8'hff;
      a2.tlast  = 1'b1;
      a2.tuser  = 1'b0;
      @(negedge clk);
      a2.tvalid = 1'b0;
      while (v2.valid !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (v2.valid !== 1'b1) begin
         bad++;
         $display("FAIL byte_rev_timeout: valid=%b want 1 within 8 cycles", v2.valid);
      end else if (v2.data !== 64'h0001020304050607 ||
                   v2.startofpacket !== 1'b1 || v2.endofpacket !== 1'b1) begin
         bad++;
         $display("FAIL byte_rev: data=%h sop=%b eop=%b want 0001020304050607 1 1",
                  v2.data, v2.startofpacket, v2.endofpacket);
      end
      @(negedge clk);
      v2.ready = 1'b0;
   endtask

   task automatic test_latency_toggle();
      exp_t        q [$];
      logic [63:0] d;
      int          pat [8];
      logic        expv;
      pat = '{1, 1, 0, 0, 1, 1, 1, 1};
      v2.ready = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         total++;
         if (a2.tready !== (i < 4) || v2.valid !== 1'b0) begin
            bad++;
            $display("FAIL toggle_fill%0d: tready=%b valid=%b want %b 0",
                     i, a2.tready, v2.valid, i < 4);
         end
         if (i < 4) begin
            d = {$urandom, $urandom};
            a2.tvalid = 1'b1;
            a2.tdata  = d;
            a2.tkeep  = (i == 3) ? 8'h3f : 8'hff;
            a2.tlast  = (i == 3);
            a2.tuser  = (i == 3);
            q.push_back(model(d, a2.tkeep, i == 3, i == 3, i == 0, 1'b1));
         end else begin
            a2.tvalid = 1'b0;
         end
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         v2.ready = pat[c][0];
         #1;
         expv = (c >= 2) && (pat[c-2] != 0) && (q.size() > 0);
         total++;
         if (v2.valid !== expv) begin
            bad++;
            $display("FAIL toggle_valid%0d: got %b want %b", c, v2.valid, expv);
         end
         if (v2.valid === 1'b1 && q.size() > 0) begin
            total++;
            if (obs2 !== q[0]) begin
               bad++;
               $display("FAIL toggle_beat%0d: got %h want %h", c, obs2, q[0]);
            end
            void'(q.pop_front());
         end
      end
      total++;
      if (a2.tready !== 1'b1 || q.size() != 0) begin
         bad++;
         $display("FAIL toggle_drain: tready=%b left=%0d want 1 0", a2.tready, q.size());
      end
      v2.ready = 1'b0;
   endtask

   task automatic test_random_lat(input int frames);
      exp_t        q [$];
      exp_t        pend;
      int          rh [$];
      bit          have_pend = 1'b0;
      bit          acc = 1'b1;
      bit          inpkt = 1'b0;
      int          sent = 0;
      int          cyc = 0;
      int          left;
      logic        expv;
      logic [63:0] d;
      logic [7:0]  k;
      logic        last;
      logic        user;
      v2.ready = 1'b0;
      repeat (3) @(negedge clk);
      rh.push_back(0);
      rh.push_back(0);
      left = $urandom_range(1, 20);
      d    = {$urandom, $urandom};
      last = (left == 1);
      k    = last ? rand_keep() : 8'hff;
      user = 1'($urandom_range(0, 1));
      while ((sent < frames || q.size() > 0 || have_pend) && cyc < 15000) begin
         @(negedge clk);
         cyc++;
         if (sent >= frames)
            a2.tvalid = 1'b0;
         else if (acc || !a2.tvalid)
            a2.tvalid = ($urandom_range(0, 3) != 0);
         acc = 1'b0;
         a2.tdata = d;
         a2.tkeep = k;
         a2.tlast = last;
         a2.tuser = user;
         v2.ready = 1'($urandom_range(0, 1));
         rh.push_back(int'(v2.ready));
         #1;
         expv = (rh[rh.size()-3] != 0) && (q.size() > 0);
         total++;
         if (v2.valid !== expv) begin
            bad++;
            $display("FAIL lat_valid: got %b want %b", v2.valid, expv);
         end
         if (v2.valid === 1'b1 && q.size() > 0) begin
            total++;
            if (obs2 !== q[0]) begin
               bad++;
               $display("FAIL lat_beat: got %h want %h", obs2, q[0]);
            end
            void'(q.pop_front());
         end
         if (have_pend) begin
            q.push_back(pend);
            have_pend = 1'b0;
         end
         total++;
         if (a2.tready !== (q.size() < 4)) begin
            bad++;
            $display("FAIL lat_tready: got %b want %b", a2.tready, q.size() < 4);
         end
         if (a2.tvalid && a2.tready === 1'b1) begin
            pend      = model(d, k, last, user, !inpkt, 1'b1);
            have_pend = 1'b1;
            acc       = 1'b1;
            inpkt     = !last;
            if (last) begin
               sent++;
               left = $urandom_range(1, 20);
            end else begin
               left--;
            end
            d    = {$urandom, $urandom};
            last = (left == 1);
            k    = last ? rand_keep() : 8'hff;
            user = 1'($urandom_range(0, 1));
         end
      end
      total++;
      if (cyc >= 15000) begin
         bad++;
         $display("FAIL lat_timeout: frames=%0d of %0d queued=%0d", sent, frames, q.size());
      end
      @(negedge clk);
      a2.tvalid = 1'b0;
      v2.ready  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_fields();
      test_random(1000);
      test_reset_mid_frame();
      test_byte_reverse();
      test_latency_toggle();
      test_random_lat(200);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/axis2avst.md
Name: axis2avst

Overview:
- Converts an AXI-Stream source into an Avalon-ST source for IP that consumes Avalon-ST, such as hard MAC TX and PCIe-adjacent Intel cores.
- Generates startofpacket/endofpacket/empty/error from tlast/tkeep/tuser and supports Avalon readyLatency 0..N.
- A small internal FIFO absorbs the beats already in flight when the sink deasserts ready.

Parameters:
DATA_WIDTH, 64, data bus width in bits
KEEP_WIDTH, DATA_WIDTH/8, tkeep width / symbols per beat
KEEP_ENABLE, (DATA_WIDTH>8), tkeep honoured; when 0, tkeep is treated as all ones and avst_empty is tied to 0
EMPTY_WIDTH, $clog2(KEEP_WIDTH), avst_empty width (min 1)
BYTE_REVERSE, 0, 1 = AXI byte n maps to Avalon symbol KEEP_WIDTH-1-n
READY_LATENCY, 0, Avalon-ST readyLatency of the sink, range 0..8
FIFO_DEPTH, 4, internal beat buffer depth; must be >= READY_LATENCY+2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
axis_tdata  in  DATA_WIDTH  stream data
axis_tkeep  in  KEEP_WIDTH  byte enables, contiguous from bit 0
axis_tvalid  in  1  beat valid
axis_tready  out  1  beat accepted when tvalid&&tready
axis_tlast  in  1  last beat of frame
axis_tuser  in  1  frame error, sampled on the tlast beat only
avst_ready  in  1  sink ready
avst_valid  out  1  beat valid
avst_data  out  DATA_WIDTH  data, byte-ordered per BYTE_REVERSE
avst_startofpacket  out  1  first beat of packet
avst_endofpacket  out  1  last beat of packet
avst_empty  out  EMPTY_WIDTH  empty symbols on EOP beat, 0 otherwise
avst_error  out  1  error, valid only with EOP

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied; in_packet flag cleared; ready delay line cleared.
  - avst_valid=0; avst_data, sop, eop, empty and error all 0; axis_tready=0.
- FIFO write side:
  - Each stored beat is {data, sop, eop, empty, error}.
  - axis_tready = rst_n && (count < FIFO_DEPTH). It is derived from registered count only, with no combinational path from avst_ready.
  - Push occurs on tvalid&&tready.
- SOP generation:
  - in_packet is set on any accepted beat and cleared on an accepted beat with tlast.
  - sop = !in_packet at acceptance.
  - A single-beat frame carries sop=eop=1.
- Empty and error:
  - On a tlast beat, empty = KEEP_WIDTH - popcount(tkeep); on other beats, empty=0.
  - error = tlast && tuser; tuser on non-last beats is ignored.
  - tkeep==0 on a tlast beat: empty = KEEP_WIDTH-1 and error forced to 1.
  - tkeep is not checked on non-last beats.
- Read side, READY_LATENCY=0:
  - avst_valid = FIFO non-empty, driven from registered state.
  - Pop on avst_valid && avst_ready.
  - Output fields present the FIFO head; they are stable while valid && !ready.
- Read side, READY_LATENCY=L>=1:
  - avst_valid may be high in cycle t only if avst_ready was high in cycle t-L.
  - Every such permitted cycle with FIFO data must carry a beat (no bubbles).
  - Every beat presented is a completed transfer and is popped.
  - Outputs are registered. When no beat is presented, avst_valid=0 and the other outputs hold their previous value.
  - After reset, no beat is presented until L cycles of sampled avst_ready have elapsed.
- Throughput: one beat per cycle sustained when ready is held high, for any L within the FIFO_DEPTH constraint.
- Latency: an accepted beat appears on Avalon no earlier than the next cycle, since the FIFO is registered.
- Simultaneous push and pop:
  - When full, tready=0 that cycle even if a pop occurs.
  - When empty, a push is not presented in the same cycle.
- Ordering: strictly in order, no drops, no reordering. Frames are not validated beyond the SOP/EOP derivation rule.
- Reset mid-frame: buffered beats are discarded. The next accepted beat is SOP.

Test Plan:
- L=0, 64-bit, 3-beat frame with tkeep on last beat = 0x0F, sink ready: beats carry sop=1,0,0 and eop=0,0,1; last-beat empty=4, error=0; data matches input.
- L=0, random tvalid and avst_ready over 1000 frames of 1..20 beats: scoreboard matches data/sop/eop/empty; tready never high while count==FIFO_DEPTH.
- L=2, FIFO_DEPTH=4:
  - Sink ready toggled 1,1,0,0,1: avst_valid follows ready delayed 2 cycles exactly.
  - Nothing is lost while ready is low; tready deasserts when 4 beats are buffered.
- Single-beat frame with tkeep=0xFF, tuser=1: sop=eop=1, empty=0, error=1. A non-last beat with tuser=1 gives error=0.
- tlast beat with tkeep=0x00: empty=7, error=1.
- BYTE_REVERSE=1, input tdata 0x0706050403020100: avst_data = 0x0001020304050607.
- rst_n pulsed low mid-frame with 2 beats buffered: avst_valid drops asynchronously. After release, the first new beat has sop=1 and stale beats never appear.
